// File: rtl/sd_io_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sd_io_pkg : shared types, constants and round-robin helper            |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package sd_io_pkg;

  localparam int SECTOR_BYTES = 512;
  localparam int LBA_W        = 32;
  localparam int MAX_REQ      = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_XFER  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ABORT = 3'd4
  } state_t;

  // Zero padding above N makes a mod-8 scan equivalent to a mod-N scan.
  function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                         input logic [2:0]         last);
    logic [2:0] idx;
    logic [2:0] pick;
    logic       found;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      idx = last + 3'(k);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sd_io_arbiter_sync2.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sync2 : two-flop synchronizer, async active-low reset to zero         |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule
`default_nettype wire

// File: rtl/sd_io_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sd_io_arbiter : round-robin share of one sector-read channel among N  |
// | sd_card requesters, with byte counting and a stall watchdog.          |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module sd_io_arbiter
  import sd_io_pkg::*;
#(
  parameter int N       = 2,
  parameter int TIMEOUT = 1 << 24
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic [N-1:0]     req_rd,
  input  logic [32*N-1:0]  req_lba,
  output logic [N-1:0]     req_ack,
  output logic [7:0]       req_din,
  output logic [N-1:0]     req_din_strobe,
  output logic [N-1:0]     req_err,
  output logic [31:0]      io_lba,
  output logic             io_rd,
  output logic [2:0]       io_sel,
  input  logic             io_ack,
  input  logic [7:0]       io_din,
  input  logic             io_din_strobe,
  output logic             busy,
  output logic [9:0]       last_count,
  output logic             short_xfer
);

  localparam int              WD_W       = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST    = WD_W'(TIMEOUT - 1);
  localparam logic [9:0]      CNT_MAX    = 10'd1023;
  localparam logic [9:0]      SECTOR_CNT = 10'(SECTOR_BYTES);

  logic [N-1:0] req_s;
  logic         ack_s;
  logic         stb_s;

  sync2 #(.WIDTH(N)) u_req_sync (.clk(clk), .n_reset(n_reset), .d(req_rd),        .q(req_s));
  sync2 #(.WIDTH(1)) u_ack_sync (.clk(clk), .n_reset(n_reset), .d(io_ack),        .q(ack_s));
  sync2 #(.WIDTH(1)) u_stb_sync (.clk(clk), .n_reset(n_reset), .d(io_din_strobe), .q(stb_s));

  state_t            state_q, state_d;
  logic [2:0]        grant_q, grant_d;
  logic [N-1:0]      grant_oh_q, grant_oh_d;
  logic [2:0]        last_grant_q, last_grant_d;
  logic [LBA_W-1:0]  io_lba_q, io_lba_d;
  logic              io_rd_q, io_rd_d;
  logic [9:0]        cnt_q, cnt_d;
  logic [9:0]        last_count_q, last_count_d;
  logic              short_q, short_d;
  logic [N-1:0]      err_q, err_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              ack_prev_q, stb_prev_q;

  logic              ack_rise;
  logic              ack_fall;
  logic              stb_fall;
  logic [MAX_REQ-1:0] req_pad;
  logic [2:0]        pick;
  logic [9:0]        cnt_inc;

  assign ack_rise = ack_s & ~ack_prev_q;
  assign ack_fall = ~ack_s & ack_prev_q;
  assign stb_fall = ~stb_s & stb_prev_q;

  always_comb begin
    req_pad          = '0;
    req_pad[N-1:0]   = req_s;
    pick             = rr_pick(req_pad, last_grant_q);
    cnt_inc          = (stb_fall && (cnt_q != CNT_MAX)) ? cnt_q + 10'd1 : cnt_q;

    state_d          = state_q;
    grant_d          = grant_q;
    grant_oh_d       = grant_oh_q;
    last_grant_d     = last_grant_q;
    io_lba_d         = io_lba_q;
    io_rd_d          = io_rd_q;
    cnt_d            = cnt_q;
    last_count_d     = last_count_q;
    short_d          = short_q;
    err_d            = '0;
    wd_d             = wd_q;

    case (state_q)
      ST_IDLE: begin
        if (|req_s) begin
          grant_d = pick;
          for (int i = 0; i < N; i++) begin
            grant_oh_d[i] = (pick == 3'(i));
            if (pick == 3'(i)) io_lba_d = req_lba[i*LBA_W +: LBA_W];
          end
          io_rd_d = 1'b1;
          cnt_d   = '0;
          short_d = 1'b0;
          wd_d    = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (ack_rise) begin
          io_rd_d = 1'b0;
          state_d = ST_XFER;
        end else if (wd_q == WD_LAST) begin
          // io_rd drops on this edge so it stays high exactly TIMEOUT cycles.
          io_rd_d      = 1'b0;
          err_d        = grant_oh_q;
          last_count_d = '0;
          state_d      = ST_ABORT;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      ST_XFER: begin
        cnt_d = cnt_inc;
        if (ack_fall) begin
          last_count_d = cnt_inc;
          short_d      = (cnt_inc != SECTOR_CNT);
          state_d      = ST_DONE;
        end
      end
      ST_DONE: begin
        if ((req_s & grant_oh_q) == '0) begin
          last_grant_d = grant_q;
          state_d      = ST_IDLE;
        end
      end
      ST_ABORT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      grant_oh_q   <= '0;
      last_grant_q <= 3'(N - 1);
      io_lba_q     <= '0;
      io_rd_q      <= 1'b0;
      cnt_q        <= '0;
      last_count_q <= '0;
      short_q      <= 1'b0;
      err_q        <= '0;
      wd_q         <= '0;
      ack_prev_q   <= 1'b0;
      stb_prev_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      grant_oh_q   <= grant_oh_d;
      last_grant_q <= last_grant_d;
      io_lba_q     <= io_lba_d;
      io_rd_q      <= io_rd_d;
      cnt_q        <= cnt_d;
      last_count_q <= last_count_d;
      short_q      <= short_d;
      err_q        <= err_d;
      wd_q         <= wd_d;
      ack_prev_q   <= ack_s;
      stb_prev_q   <= stb_s;
    end
  end

  // Raw-input steering keeps the sd_card's own edge timing intact.
  assign req_ack        = {N{io_ack}} & grant_oh_q;
  assign req_din_strobe = {N{io_din_strobe}} & grant_oh_q;
  assign req_din        = io_din;
  assign req_err        = err_q;
  assign io_lba         = io_lba_q;
  assign io_rd          = io_rd_q;
  assign io_sel         = grant_q;
  assign busy           = (state_q != ST_IDLE);
  assign last_count     = last_count_q;
  assign short_xfer     = short_q;

endmodule
`default_nettype wire

// File: tb/tb_sd_io_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for sd_io_arbiter: plays io controller and two sd_card requesters.
module tb_sd_io_arbiter;

  localparam int N  = 2;
  localparam int TO = 64;

  logic              clk = 1'b0;
  logic              n_reset = 1'b1;
  logic [N-1:0]      req_rd = '0;
  logic [31:0]       lba_m [N];
  logic [32*N-1:0]   req_lba;
  logic [N-1:0]      req_ack, req_din_strobe, req_err;
  logic [7:0]        req_din;
  logic [31:0]       io_lba;
  logic              io_rd;
  logic [2:0]        io_sel;
  logic              io_ack = 1'b0;
  logic [7:0]        io_din = '0;
  logic              io_din_strobe = 1'b0;
  logic              busy;
  logic [9:0]        last_count;
  logic              short_xfer;

  int                tests = 0;
  int                fails = 0;
  logic [N-1:0]      model_oh = '0;
  int                pending = 0;
  int                last_g = N - 1;
  int                stb_cnt [N] = '{default: 0};
  logic [N-1:0]      prev_stb = '0;

  assign req_lba = {lba_m[1], lba_m[0]};

  always #5 clk = ~clk;

  sd_io_arbiter #(.N(N), .TIMEOUT(TO)) dut (
    .clk(clk), .n_reset(n_reset), .req_rd(req_rd), .req_lba(req_lba),
    .req_ack(req_ack), .req_din(req_din), .req_din_strobe(req_din_strobe),
    .req_err(req_err), .io_lba(io_lba), .io_rd(io_rd), .io_sel(io_sel),
    .io_ack(io_ack), .io_din(io_din), .io_din_strobe(io_din_strobe),
    .busy(busy), .last_count(last_count), .short_xfer(short_xfer)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic int rr_model(input int pend, input int last);
    for (int k = 1; k <= N; k++)
      if (((pend >> ((last + k) % N)) & 1) == 1) return (last + k) % N;
    return -1;
  endfunction

  task automatic raise(input int mask);
    for (int i = 0; i < N; i++)
      if (((mask >> i) & 1) == 1 && ((pending >> i) & 1) == 0) begin
        lba_m[i]  = $urandom;
        req_rd[i] = 1'b1;
        pending  |= (1 << i);
      end
  endtask

  // Steering is combinational: granted requester sees raw ack/strobe, others 0.
  always @(negedge clk) begin
    check("steer_ack", 32'(req_ack), 32'(io_ack ? model_oh : {N{1'b0}}));
    check("steer_strobe", 32'(req_din_strobe), 32'(io_din_strobe ? model_oh : {N{1'b0}}));
    check("din_pass", 32'(req_din), 32'(io_din));
    for (int i = 0; i < N; i++)
      if (req_din_strobe[i] && !prev_stb[i]) stb_cnt[i] <= stb_cnt[i] + 1;
    prev_stb <= req_din_strobe;
  end

  task automatic do_txn(input bit wd_mode, input int nbytes, input int add_mask, output int win);
    int exp_w, c, hi, errbad, expc;
    int s0 [N];
    exp_w = rr_model(pending, last_g);
    win   = exp_w;
    if (exp_w < 0) begin
      check("pending_nonempty", 0, 1);
      return;
    end
    c = 0;
    while (!io_rd && c < 20) begin
      tick();
      c++;
    end
    check("io_rd_rise", 32'(io_rd), 1);
    if (!io_rd) return;
    check("io_sel", 32'(io_sel), exp_w);
    check("io_lba", io_lba, lba_m[exp_w]);
    check("short_clr", 32'(short_xfer), 0);
    check("busy_issue", 32'(busy), 1);
    model_oh = N'(1 << exp_w);

    if (wd_mode) begin
      hi = 0;
      errbad = 0;
      while (io_rd && hi < 200) begin
        if (req_err != '0) errbad++;
        hi++;
        tick();
      end
      check("wd_len", hi, TO);
      check("wd_err_quiet", errbad, 0);
      check("wd_err_pulse", 32'(req_err), 32'(model_oh));
      check("wd_last_count", 32'(last_count), 0);
      tick();
      check("wd_err_clear", 32'(req_err), 0);
      check("wd_idle", 32'(busy), 0);
      return;
    end

    repeat ($urandom_range(0, 3)) tick();
    io_ack = 1'b1;
    tick();
    tick();
    check("ack_hold", 32'(io_rd), 1);
    tick();
    check("ack_xfer", 32'(io_rd), 0);
    tick();
    raise(add_mask);
    for (int i = 0; i < N; i++) s0[i] = stb_cnt[i];
    for (int b = 0; b < nbytes; b++) begin
      io_din        = 8'($urandom);
      io_din_strobe = 1'b1;
      tick();
      io_din_strobe = 1'b0;
      tick();
      tick();
      if ($urandom_range(0, 1) == 1) tick();
    end
    tick();
    tick();
    tick();
    io_ack = 1'b0;
    repeat (5) tick();
    expc = (nbytes > 1023) ? 1023 : nbytes;
    check("last_count", 32'(last_count), expc);
    check("short_xfer", 32'(short_xfer), 32'(expc != 512));
    check("busy_done", 32'(busy), 1);
    for (int i = 0; i < N; i++)
      check(i == exp_w ? "strobe_win" : "strobe_other", stb_cnt[i] - s0[i], i == exp_w ? nbytes : 0);
    req_rd[exp_w] = 1'b0;
    pending &= ~(1 << exp_w);
    last_g = exp_w;
    repeat (4) tick();
    if (pending == 0) check("busy_idle", 32'(busy), 0);
  endtask

  task automatic reset_dut();
    #1 n_reset = 1'b0;
    model_oh      = '0;
    req_rd        = '0;
    pending       = 0;
    last_g        = N - 1;
    io_ack        = 1'b0;
    io_din_strobe = 1'b0;
    tick();
    tick();
    n_reset = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    int w, w0, w1, w2, w3, nb, r, add, c;
    bit wd;
    for (int i = 0; i < N; i++) lba_m[i] = '0;
    io_ack        = 1'b1;
    io_din_strobe = 1'b1;
    #1 n_reset = 1'b0;
    repeat (3) tick();
    check("rst_io_rd", 32'(io_rd), 0);
    check("rst_io_lba", io_lba, 0);
    check("rst_io_sel", 32'(io_sel), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_req_err", 32'(req_err), 0);
    check("rst_last_count", 32'(last_count), 0);
    check("rst_short", 32'(short_xfer), 0);
    check("rst_req_ack", 32'(req_ack), 0);
    check("rst_req_strobe", 32'(req_din_strobe), 0);
    io_ack        = 1'b0;
    io_din_strobe = 1'b0;
    tick();
    n_reset = 1'b1;
    tick();
    tick();

    // Single request with request-to-io_rd latency.
    raise(1);
    lba_m[0] = 32'h1234;
    tick();
    check("lat_e1", 32'(io_rd), 0);
    tick();
    check("lat_e2", 32'(io_rd), 0);
    tick();
    check("lat_e3", 32'(io_rd), 1);
    do_txn(0, 512, 0, w);
    check("t1_win", w, 0);
    check("t1_lba", io_lba, 32'h1234);
    check("t1_sel", 32'(io_sel), 0);
    check("t1_count", 32'(last_count), 512);
    check("t1_short", 32'(short_xfer), 0);

    // Contention after reset.
    reset_dut();
    raise(3);
    do_txn(0, 512, 0, w0);
    do_txn(0, 512, 1, w1);
    do_txn(0, 512, 2, w2);
    do_txn(0, 512, 0, w3);
    check("rr_0", w0, 0);
    check("rr_1", w1, 1);
    check("rr_2", w2, 0);
    check("rr_3", w3, 1);

    // Watchdog then re-grant with a short transfer.
    raise(1);
    do_txn(1, 0, 0, w);
    check("wd_win", w, 0);
    do_txn(0, 100, 0, w);
    check("short_win", w, 0);
    check("short_count", 32'(last_count), 100);
    check("short_flag", 32'(short_xfer), 1);
    raise(2);
    do_txn(0, 512, 0, w);
    check("after_short_win", w, 1);
    check("after_short_flag", 32'(short_xfer), 0);

    // Reset in the middle of a transfer.
    raise(1);
    c = 0;
    while (!io_rd && c < 20) begin
      tick();
      c++;
    end
    check("mid_io_rd", 32'(io_rd), 1);
    model_oh = N'(1);
    io_ack   = 1'b1;
    repeat (4) tick();
    for (int b = 0; b < 200; b++) begin
      io_din_strobe = 1'b1;
      tick();
      io_din_strobe = 1'b0;
      tick();
      tick();
    end
    io_din_strobe = 1'b1;
    #1 n_reset = 1'b0;
    model_oh = '0;
    #1;
    check("mid_rst_io_rd", 32'(io_rd), 0);
    check("mid_rst_ack", 32'(req_ack), 0);
    check("mid_rst_strobe", 32'(req_din_strobe), 0);
    check("mid_rst_busy", 32'(busy), 0);
    io_ack        = 1'b0;
    io_din_strobe = 1'b0;
    req_rd        = '0;
    pending       = 0;
    last_g        = N - 1;
    tick();
    tick();
    n_reset = 1'b1;
    repeat (3) tick();
    check("post_rst_busy", 32'(busy), 0);
    raise(2);
    do_txn(0, 512, 0, w);
    check("post_rst_win", w, 1);

    // Randomized traffic against the model.
    for (int it = 0; it < 20; it++) begin
      if (pending == 0) raise($urandom_range(1, 3));
      wd  = ($urandom_range(0, 7) == 0);
      r   = $urandom_range(0, 9);
      nb  = (r < 3) ? 512 : (r == 9) ? $urandom_range(1020, 1030) : $urandom_range(0, 600);
      add = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      do_txn(wd, nb, add, w);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: got no finish, expected finish before %0t", $time);
    $fatal(1, "bench time limit reached");
  end

endmodule
`default_nettype wire
